serial_and_reduce: RTL and testbench
====================================

# serial_and_reduce

Frame-level AND reducer that sits directly upstream of the two-input AND stage. It accepts a valid/ready stream of W-bit words and computes the bitwise AND of every word in a frame delimited by `up_last`. It presents one result word per frame on a valid/ready output held in a single-entry output register. It is the sequential counterpart of the combinational AND: it folds an arbitrarily long operand sequence into one word that the downstream AND stage consumes.

## Interface
- `W`, default 8: data width in bits, ≥1.
- `CNT_W`, default 8: width of the beat counter, ≥1. Present only with the configuration macro.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `up_valid` input 1: upstream word valid.
- `up_ready` output 1: block can accept a word this cycle.
- `up_data` input W: operand word.
- `up_last` input 1: marks the final word of a frame; qualified by `up_valid`.
- `down_valid` output 1: frame result available.
- `down_ready` input 1: downstream accepts the result.
- `down_data` output W: bitwise AND of all words in the frame.
- `down_count` output CNT_W: number of words in the frame. Present only with the configuration macro.

## Operation
- Two states:
  - ACCUM: collecting a frame, `up_ready=1`, `down_valid=0`.
  - HOLD: result registered, `up_ready=0`, `down_valid=1`.
- Accumulator `acc` (W bits) is all-ones at the start of every frame.
- An upstream beat is `up_valid && up_ready`.
- Beat in ACCUM without `up_last`: `acc <= acc & up_data`; stay in ACCUM.
- Beat in ACCUM with `up_last`:
  - `down_data <= acc & up_data`.
  - `acc <=` all-ones.
  - Go to HOLD.
- HOLD with `down_ready=1`: go to ACCUM. The result is consumed this cycle.
- HOLD with `down_ready=0`: stay in HOLD. `down_data` (and `down_count`) stay stable.
- `up_valid` in HOLD is ignored: no beat occurs and the upstream must hold its word.
- A single-word frame (`up_last` on the first beat) yields `down_data = up_data`.
- There are no empty frames: every frame contains at least its `up_last` word.
- `up_data` and `up_last` are don't-care when `up_valid=0`.
- `down_valid` and `up_ready` are driven directly from state registers, with no combinational path from inputs.

## Timing
- Reset values:
  - State ACCUM, so `up_ready=1` and `down_valid=0`.
  - `acc` all-ones.
  - `down_data=0`.
  - `down_count=0`.
- Latency: `down_valid` rises in the cycle after the `up_last` beat.
- Throughput: one word per cycle within a frame.
- Each frame costs at least one extra HOLD cycle; the minimum period for back-to-back single-word frames is 2 cycles.
- `up_ready` returns to 1 in the cycle after `down_ready` is sampled high in HOLD.
- Reset asserted mid-frame: the partial accumulation is discarded; the next beat after reset starts a new frame.
- Reset asserted in HOLD: the pending result is dropped and `down_valid=0` in the next cycle.
- `rst` has priority over every other input in the same cycle.

## Configuration
- Macro: `SERIAL_AND_REDUCE_COUNT_EN`.
- When defined:
  - `CNT_W` and `down_count` exist.
  - An internal counter increments on every beat and is cleared when a new frame begins.
  - `down_count` is registered alongside `down_data` on the `up_last` beat, including the last word.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
- When undefined: no counter logic and no `down_count` port. All other behaviour is identical.

## Test plan
- After reset, without driving inputs: `up_ready=1`, `down_valid=0`, `down_data=0x00`.
- Frame 0xF0, 0x3C, 0xFF (last), `down_ready=1` → one cycle later `down_valid=1` with `down_data=0x30` (`down_count=3` when enabled). The next cycle returns to ACCUM.
- Single-word frame 0xA5 (last) with `down_ready=0` for 4 cycles → `down_data=0xA5` held stable, `up_ready=0` throughout, and `up_valid` words offered during HOLD are not absorbed. When `down_ready` rises, the result is consumed, and with `up_valid` still held the held word is absorbed the cycle after.
- Back-to-back frames [0x0F, last] then [0xFF, 0x81 last] with `up_valid` continuously high → results 0x0F then 0x81, no lost or merged frames.
- Frame 0xFF, 0xEE, then `rst` for 1 cycle, then 0x11 (last) → `down_data=0x11`, not 0x00 (`down_count=1`).
- With `SERIAL_AND_REDUCE_COUNT_EN` and `CNT_W=2`, a 6-word frame of 0xFF → `down_count=3` (saturated), `down_data=0xFF`.

Source files
------------

// File: rtl/serial_and_reduce.sv
// Frame-level AND reducer: folds a valid/ready word stream into one AND result per frame.
// Optional beat counter on down_count is enabled by defining SERIAL_AND_REDUCE_COUNT_EN.
module serial_and_reduce #(
  parameter int W = 8
`ifdef SERIAL_AND_REDUCE_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [W-1:0]     up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [W-1:0]     down_data
`ifdef SERIAL_AND_REDUCE_COUNT_EN
  , output logic [CNT_W-1:0] down_count
`endif
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_down_data;
  logic [W-1:0]   w_acc_next;
  logic           w_beat;

  // Handshake outputs come straight from the state register, never from inputs.
  assign up_ready   = (r_state == ACCUM);
  assign down_valid = (r_state == HOLD);
  assign down_data  = r_down_data;

  assign w_beat     = up_valid && (r_state == ACCUM);
  assign w_acc_next = r_acc & up_data;

`ifdef SERIAL_AND_REDUCE_COUNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_down_count;
  logic [CNT_W-1:0] w_cnt_inc;

  // Saturating increment: the count sticks at all-ones on long frames.
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign down_count = r_down_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_down_count <= '0;
    end else if (w_beat) begin
      if (up_last) begin
        r_down_count <= w_cnt_inc;
        r_cnt        <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '1;
      r_down_data <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_beat) begin
            if (up_last) begin
              r_down_data <= w_acc_next;
              r_acc       <= '1;
              r_state     <= HOLD;
            end else begin
              r_acc <= w_acc_next;
            end
          end
        end
        HOLD: begin
          if (down_ready) begin
            r_state <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_and_reduce.sv
// Scoreboard bench for serial_and_reduce: directed frames plus random traffic,
// expected results computed per frame from the list of accepted words.
module tb_serial_and_reduce;

  localparam int W = 8;
`ifdef SERIAL_AND_REDUCE_COUNT_EN
  localparam int CNT_W = 2;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;
`endif

  logic         clk;
  logic         rst;
  logic         up_valid;
  logic         up_ready;
  logic [W-1:0] up_data;
  logic         up_last;
  logic         down_valid;
  logic         down_ready;
  logic [W-1:0] down_data;
`ifdef SERIAL_AND_REDUCE_COUNT_EN
  logic [CNT_W-1:0] down_count;
`endif

  serial_and_reduce #(
    .W(W)
`ifdef SERIAL_AND_REDUCE_COUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_last    (up_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
`ifdef SERIAL_AND_REDUCE_COUNT_EN
    , .down_count (down_count)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    int unsigned  n;
    int unsigned  cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [W-1:0] frame_words[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          rdy_mode = 0;

  initial begin
    clk = 1'b0;
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: result is the AND of all words accepted in the frame, count is the word total.
  task automatic close_frame(input int unsigned beat_cyc);
    exp_t e;
    e.d = '1;
    foreach (frame_words[i]) e.d = e.d & frame_words[i];
    e.n = frame_words.size();
`ifdef SERIAL_AND_REDUCE_COUNT_EN
    if (e.n > CMAX) e.n = CMAX;
`endif
    e.cyc = beat_cyc;
    exp_q.push_back(e);
    frame_words.delete();
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    up_valid = 1'b1;
    up_data  = d;
    up_last  = last;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (up_ready) begin
        frame_words.push_back(d);
        if (last) close_frame(cyc + 1);
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("up_ready_timeout", 32'(up_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    up_valid = 1'b0;
    up_data  = W'($urandom);
    up_last  = 1'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    up_valid = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    frame_words.delete();
    @(negedge clk);
    chk("rst_up_ready", 32'(up_ready), 32'd1);
    chk("rst_down_valid", 32'(down_valid), 32'd0);
    chk("rst_down_data", 32'(down_data), 32'd0);
`ifdef SERIAL_AND_REDUCE_COUNT_EN
    chk("rst_down_count", 32'(down_count), 32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !down_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    exp_t         e;
    bit           in_hold;
    logic [W-1:0] held;
    int           nw;
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    up_last    = 1'b0;
    down_ready = 1'b0;
    in_hold    = 1'b0;
    held       = '0;

    fork
      // Monitor: pops one expectation per result and checks it stays put while held.
      forever begin
        @(negedge clk);
        if (rst) begin
          in_hold = 1'b0;
        end else begin
          chk("up_ready_vs_down_valid", 32'(up_ready), 32'(!down_valid));
          if (down_valid) begin
            if (!in_hold) begin
              if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(down_valid), 32'd0);
              end else begin
                e = exp_q.pop_front();
                chk("result_latency", cyc, e.cyc);
                chk("down_data", 32'(down_data), 32'(e.d));
`ifdef SERIAL_AND_REDUCE_COUNT_EN
                chk("down_count", 32'(down_count), e.n);
`endif
              end
              held    = down_data;
              in_hold = 1'b1;
            end else begin
              chk("hold_stable", 32'(down_data), 32'(held));
            end
            if (down_ready) in_hold = 1'b0;
          end else if (in_hold) begin
            chk("down_valid_held", 32'(down_valid), 32'd1);
            in_hold = 1'b0;
          end
        end
      end

      forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
          0:       down_ready = 1'b1;
          1:       down_ready = 1'($urandom_range(0, 1));
          default: down_ready = 1'b0;
        endcase
      end

      begin
        repeat (40000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: run did not finish within cycle budget");
      end

      begin
        do_reset(2);

        send(8'hF0, 1'b0);
        send(8'h3C, 1'b0);
        send(8'hFF, 1'b1);
        idle(3);

        rdy_mode = 2;
        idle(2);
        send(8'hA5, 1'b1);
        fork
          send(8'h5A, 1'b1);
          begin
            repeat (4) @(posedge clk);
            rdy_mode = 0;
          end
        join
        idle(3);

        send(8'h0F, 1'b1);
        send(8'hFF, 1'b0);
        send(8'h81, 1'b1);
        idle(3);

        send(8'hFF, 1'b0);
        send(8'hEE, 1'b0);
        do_reset(1);
        send(8'h11, 1'b1);
        idle(3);

        rdy_mode = 2;
        idle(1);
        send(8'h77, 1'b1);
        idle(2);
        do_reset(1);
        rdy_mode = 0;

        for (int i = 0; i < 6; i++) send(8'hFF, 1'(i == 5));
        idle(3);
        for (int i = 0; i < 5; i++) send(8'hF7, 1'(i == 4));
        idle(3);

        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
          nw = $urandom_range(1, 8);
          for (int i = 0; i < nw; i++) begin
            send(~(W'($urandom) & W'($urandom) & W'($urandom)), 1'(i == nw - 1));
            if ($urandom_range(0, 3) == 0) idle(1);
          end
        end
        idle(1);
        rdy_mode = 0;
        drain();
      end
    join_any

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
